psum_accum_arr: RTL and testbench
=================================

Name: psum_accum_arr

Overview:
- Downstream neighbour of the PE multiplier array; consumes its per-lane products (data_out[MUL_NUM-1:0]) and its PE_STATE tag (state_out).
- Each lane accumulates products over a convolution window, which ends when a CNN_FIN beat arrives.
- At window end, each lane requantizes its sum (arithmetic shift, saturate, optional ReLU) and presents it on a valid/ready output with a 2-deep result buffer.
- Feeds the output activation writer.

Parameters:
- DATA_WID, 8: width of each signed input product.
- ACC_WID, 20: signed accumulator width per lane.
- OUT_WID, 8: signed result width per lane.
- SHIFT, 0: arithmetic right shift applied to the final sum before saturation.
- MUL_NUM, 4: number of lanes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- state_in  in  PE_STATE  beat tag: INVALID, VALID or CNN_FIN.
- data_in  in  [DATA_WID-1:0] x MUL_NUM  signed per-lane products, aligned with state_in.
- relu_en  in  1  clamps negative results to 0; sampled on the CNN_FIN beat.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  [OUT_WID-1:0] x MUL_NUM  signed requantized results.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts out_data.
- ovf_err  out  1  sticky flag: a beat was dropped.

Behaviour:
- Reset (reset=0, asynchronous): accumulators=0, both result slots empty, out_valid=0, out_data=0, in_ready=1, ovf_err=0, FSM=IDLE. Effect is immediate, mid-window included; partial sums are discarded.
- Beat acceptance: a beat is accepted when state_in!=INVALID and in_ready=1. INVALID beats never change state.
- FSM IDLE: stays in IDLE on INVALID.
  - VALID accepted: acc = data_in (sign-extended); go to ACCUM.
  - CNN_FIN accepted: single-beat window; result = data_in; stay in IDLE.
- FSM ACCUM:
  - VALID: acc += data_in.
  - INVALID: hold acc (bubbles are allowed inside a window).
  - CNN_FIN: final = acc + data_in; push result; acc cleared to 0; go to IDLE.
- Accumulation arithmetic:
  - Each add saturates to the signed ACC_WID range (max 2^(ACC_WID-1)-1, min -2^(ACC_WID-1)). No wrap.
- Requantize, per lane, computed combinationally from final:
  - q = final >>> SHIFT (truncation toward -inf).
  - Saturate q to the signed OUT_WID range (127/-128 at default width).
  - If relu_en=1 and q<0, q=0.
- Result buffer:
  - Slot R0 drives out_data/out_valid; slot R1 is pending.
  - A push goes to R0 if R0 is empty, or if R0 is draining this cycle (out_valid&&out_ready) and R1 is empty; otherwise it goes to R1.
  - On a drain, R1 moves to R0 in the same cycle.
  - A push and a drain in the same cycle are both honoured.
  - Latency: CNN_FIN accepted at edge t means out_valid=1 with the result after edge t (visible in cycle t+1) when R0 was empty.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - out_data returns to 0 when the buffer empties.
- in_ready: registered; in_ready = !R1_full.
- Dropped beats: a non-INVALID beat presented while in_ready=0 is dropped; ovf_err is set and held until reset. The upstream PE has no stall, so the controller must keep at most 2 windows outstanding.
- Lanes are independent; the same FSM and buffer control are shared across all lanes.

Test Plan:
1. Basic window (SHIFT=0): 8 VALID beats with lanes {1,2,3,4} incremented by 1 per beat, then CNN_FIN with {9,10,11,12}, out_ready=1. Required: one cycle after FIN, out_valid=1 and out_data={45,54,63,72} for exactly 1 cycle.
2. Saturation and shift:
   - 9 beats of 127 on all lanes, SHIFT=0: out=127 (sum 1143 saturated).
   - Rebuild with SHIFT=2 and 4 beats of 100: out=100.
   - 4 beats of -128 with SHIFT=0: out=-128.
3. ReLU: window summing to {-50,50,-1,0} with relu_en=1 gives {0,50,0,0}; the same window with relu_en=0 gives {-50,50,-1,0}.
4. Backpressure: out_ready=0 while two single-beat CNN_FIN windows arrive ({5,...}, then {6,...}). Required: in_ready=0 after the second window, and out_data stays at 5s.
   - A third beat is sent: it is dropped and ovf_err=1.
   - Raise out_ready: 5s then 6s, one per cycle; out_valid then falls and in_ready returns to 1.
5. Bubbles and reset: VALID {1}, INVALID x3, VALID {2}, CNN_FIN {3} gives 6 per lane.
   - Assert reset mid-window after two VALID beats: out_valid=0 and ovf_err=0 immediately.
   - After release, the next window {7} FIN gives 7, with no residue from the aborted window.

Source files
------------

// File: rtl/psum_accum_arr.sv
// Per-lane partial-sum accumulator with requantization and a 2-deep result buffer.
// Latency: result visible one cycle after the CNN_FIN beat is accepted (if R0 empty).
// Backpressure: in_ready drops when both result slots are full; beats offered then are dropped and flagged.
package psum_pkg;
   typedef enum logic [1:0] {
      INVALID = 2'd0,
      VALID   = 2'd1,
      CNN_FIN = 2'd2
   } pe_state_t;
endpackage

module psum_accum_arr
   import psum_pkg::*;
#(
   parameter int DATA_WID = 8,
   parameter int ACC_WID  = 20,
   parameter int OUT_WID  = 8,
   parameter int SHIFT    = 0,
   parameter int MUL_NUM  = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  pe_state_t                         state_in,
   input  logic [MUL_NUM-1:0][DATA_WID-1:0]  data_in,
   input  logic                              relu_en,
   output logic                              in_ready,
   output logic [MUL_NUM-1:0][OUT_WID-1:0]   out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              ovf_err
);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} fsm_t;

   // Bounds of the signed output range, expressed at accumulator width for comparison.
   localparam logic signed [ACC_WID-1:0] OUT_MAX = {{(ACC_WID-OUT_WID+1){1'b0}}, {(OUT_WID-1){1'b1}}};
   localparam logic signed [ACC_WID-1:0] OUT_MIN = {{(ACC_WID-OUT_WID+1){1'b1}}, {(OUT_WID-1){1'b0}}};

   // Add a sign-extended product to the accumulator, clamping instead of wrapping.
   function automatic logic [ACC_WID-1:0] sat_add(input logic signed [ACC_WID-1:0] a,
                                                   input logic signed [DATA_WID-1:0] b);
      logic signed [ACC_WID:0] s;
      s = {a[ACC_WID-1], a} + {{(ACC_WID+1-DATA_WID){b[DATA_WID-1]}}, b};
      if (s[ACC_WID] != s[ACC_WID-1])
         return s[ACC_WID] ? {1'b1, {(ACC_WID-1){1'b0}}} : {1'b0, {(ACC_WID-1){1'b1}}};
      return s[ACC_WID-1:0];
   endfunction

   // Shift toward -inf, clamp to output range, then optionally clip negatives.
   function automatic logic [OUT_WID-1:0] requant(input logic signed [ACC_WID-1:0] f,
                                                   input logic relu);
      logic signed [ACC_WID-1:0] q;
      q = f >>> SHIFT;
      if (q > OUT_MAX)      q = OUT_MAX;
      else if (q < OUT_MIN) q = OUT_MIN;
      if (relu && q[ACC_WID-1]) q = '0;
      return q[OUT_WID-1:0];
   endfunction

   fsm_t                              st, st_nxt;
   logic [MUL_NUM-1:0][ACC_WID-1:0]   acc;
   logic [MUL_NUM-1:0][ACC_WID-1:0]   sum;
   logic [MUL_NUM-1:0][OUT_WID-1:0]   res;
   logic [MUL_NUM-1:0][OUT_WID-1:0]   r0_dat, r1_dat;
   logic                              r0_vld, r1_vld;
   logic                              accept, acc_ld, acc_clr, push, drain;

   assign accept    = (state_in != INVALID) && in_ready;
   assign drain     = r0_vld && out_ready;
   assign in_ready  = !r1_vld;
   assign out_valid = r0_vld;
   assign out_data  = r0_dat;

   // Per-lane running sum including the current beat, and its requantized form.
   always_comb begin
      sum = '0;
      res = '0;
      for (int i = 0; i < MUL_NUM; i++) begin
         sum[i] = sat_add((st == ACCUM) ? acc[i] : '0, data_in[i]);
         res[i] = requant(sum[i], relu_en);
      end
   end

   // Window FSM: decides whether this beat loads, clears or pushes a result.
   always_comb begin
      st_nxt  = st;
      acc_ld  = 1'b0;
      acc_clr = 1'b0;
      push    = 1'b0;
      if (accept) begin
         if (state_in == VALID) begin
            st_nxt = ACCUM;
            acc_ld = 1'b1;
         end else begin
            st_nxt  = IDLE;
            acc_clr = 1'b1;
            push    = 1'b1;
         end
      end
   end

   // FSM state, accumulators and the sticky drop flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st      <= IDLE;
         acc     <= '0;
         ovf_err <= 1'b0;
      end else begin
         st <= st_nxt;
         if (acc_ld)       acc <= sum;
         else if (acc_clr) acc <= '0;
         if ((state_in != INVALID) && !in_ready) ovf_err <= 1'b1;
      end
   end

   // Two-slot result buffer: R0 faces the consumer, R1 refills it on drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r0_vld <= 1'b0;
         r0_dat <= '0;
         r1_vld <= 1'b0;
         r1_dat <= '0;
      end else begin
         if (drain) begin
            r0_vld <= r1_vld;
            r0_dat <= r1_vld ? r1_dat : '0;
            r1_vld <= 1'b0;
            r1_dat <= '0;
         end
         if (push) begin
            if (!r0_vld || (drain && !r1_vld)) begin
               r0_vld <= 1'b1;
               r0_dat <= res;
            end else begin
               r1_vld <= 1'b1;
               r1_dat <= res;
            end
         end
      end
   end

endmodule

// File: tb/tb_psum_accum_arr.sv
// Directed bench for psum_accum_arr with a queue-based scoreboard on the result port.
// Latency: expectations are queued at stimulus time and popped on each accepted output.
// Backpressure: out_ready is held low in places to exercise the 2-deep buffer and drops.
module tb_psum_accum_arr;
   import psum_pkg::*;

   typedef logic [3:0][7:0] vec_t;

   logic      clk = 1'b0;
   logic      reset;
   pe_state_t st0, st1;
   vec_t      d0, d1;
   logic      relu0, relu1, rdy0, rdy1;
   logic      in_ready0, in_ready1, ov0, ov1, err0, err1;
   vec_t      out0, out1;

   vec_t q0[$];
   vec_t q1[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   psum_accum_arr dut0 (
      .clk(clk), .reset(reset), .state_in(st0), .data_in(d0), .relu_en(relu0),
      .in_ready(in_ready0), .out_data(out0), .out_valid(ov0), .out_ready(rdy0), .ovf_err(err0)
   );

   psum_accum_arr #(.SHIFT(2)) dut1 (
      .clk(clk), .reset(reset), .state_in(st1), .data_in(d1), .relu_en(relu1),
      .in_ready(in_ready1), .out_data(out1), .out_valid(ov1), .out_ready(rdy1), .ovf_err(err1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic vec_t v4(input int a, input int b, input int c, input int e);
      return {e[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   function automatic vec_t splat(input int x);
      return v4(x, x, x, x);
   endfunction

   task automatic send(input int which, input pe_state_t s, input vec_t d, input logic relu);
      if (which == 0) begin st0 = s; d0 = d; relu0 = relu; end
      else            begin st1 = s; d1 = d; relu1 = relu; end
      @(posedge clk);
      #1;
      st0 = INVALID;
      st1 = INVALID;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Scoreboard monitor: every accepted output must match the oldest expectation.
   always @(negedge clk) begin
      if (reset) begin
         if (ov0 && rdy0) begin
            if (q0.size() == 0) begin
               total_cnt++;
               $display("FAIL dut0 unexpected output: got %h, expected none", out0);
            end else check("dut0 result", out0, q0.pop_front());
         end
         if (ov1 && rdy1) begin
            if (q1.size() == 0) begin
               total_cnt++;
               $display("FAIL dut1 unexpected output: got %h, expected none", out1);
            end else check("dut1 result", out1, q1.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b0;
      st0 = INVALID; st1 = INVALID;
      d0 = '0; d1 = '0; relu0 = 1'b0; relu1 = 1'b0;
      rdy0 = 1'b0; rdy1 = 1'b0;
      #2;
      check("reset out_valid", 32'(ov0), 32'd0);
      check("reset out_data", out0, 32'd0);
      check("reset in_ready", 32'(in_ready0), 32'd1);
      check("reset ovf_err", 32'(err0), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(1);

      // Basic window
      rdy0 = 1'b1;
      for (int i = 0; i < 8; i++) send(0, VALID, v4(1+i, 2+i, 3+i, 4+i), 1'b0);
      q0.push_back(v4(45, 54, 63, 72));
      send(0, CNN_FIN, v4(9, 10, 11, 12), 1'b0);
      check("t1 valid after fin", 32'(ov0), 32'd1);
      idle(1);
      check("t1 valid one cycle", 32'(ov0), 32'd0);

      // Output saturation, shift, negative saturation
      for (int i = 0; i < 8; i++) send(0, VALID, splat(127), 1'b0);
      q0.push_back(splat(127));
      send(0, CNN_FIN, splat(127), 1'b0);
      idle(1);
      rdy1 = 1'b1;
      for (int i = 0; i < 3; i++) send(1, VALID, splat(100), 1'b0);
      q1.push_back(splat(100));
      send(1, CNN_FIN, splat(100), 1'b0);
      for (int i = 0; i < 3; i++) send(0, VALID, splat(-128), 1'b0);
      q0.push_back(splat(-128));
      send(0, CNN_FIN, splat(-128), 1'b0);
      idle(1);

      // ReLU on and off
      q0.push_back(v4(0, 50, 0, 0));
      send(0, VALID, v4(-25, 25, -1, 0), 1'b0);
      send(0, CNN_FIN, v4(-25, 25, 0, 0), 1'b1);
      q0.push_back(v4(-50, 50, -1, 0));
      send(0, VALID, v4(-25, 25, -1, 0), 1'b0);
      send(0, CNN_FIN, v4(-25, 25, 0, 0), 1'b0);
      idle(1);

      // Backpressure and dropped beat
      rdy0 = 1'b0;
      send(0, CNN_FIN, splat(5), 1'b0);
      check("t4 in_ready after one", 32'(in_ready0), 32'd1);
      send(0, CNN_FIN, splat(6), 1'b0);
      check("t4 in_ready full", 32'(in_ready0), 32'd0);
      check("t4 out_valid held", 32'(ov0), 32'd1);
      check("t4 out_data held", out0, splat(5));
      check("t4 ovf before drop", 32'(err0), 32'd0);
      send(0, CNN_FIN, splat(7), 1'b0);
      check("t4 ovf_err set", 32'(err0), 32'd1);
      check("t4 out_data stable", out0, splat(5));
      q0.push_back(splat(5));
      q0.push_back(splat(6));
      rdy0 = 1'b1;
      idle(1);
      check("t4 in_ready after drain", 32'(in_ready0), 32'd1);
      idle(1);
      check("t4 out_valid empty", 32'(ov0), 32'd0);
      check("t4 out_data zero", out0, 32'd0);
      check("t4 ovf_err sticky", 32'(err0), 32'd1);

      // Bubbles inside a window
      send(0, VALID, splat(1), 1'b0);
      idle(3);
      send(0, VALID, splat(2), 1'b0);
      q0.push_back(splat(6));
      send(0, CNN_FIN, splat(3), 1'b0);
      idle(1);

      // Asynchronous reset mid-window with a result pending
      rdy0 = 1'b0;
      send(0, CNN_FIN, splat(9), 1'b0);
      send(0, VALID, splat(1), 1'b0);
      send(0, VALID, splat(1), 1'b0);
      check("t5 pending before reset", 32'(ov0), 32'd1);
      reset = 1'b0;
      #1;
      check("t5 reset out_valid", 32'(ov0), 32'd0);
      check("t5 reset ovf_err", 32'(err0), 32'd0);
      check("t5 reset out_data", out0, 32'd0);
      check("t5 reset in_ready", 32'(in_ready0), 32'd1);
      rdy0 = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(1);
      q0.push_back(splat(7));
      send(0, CNN_FIN, splat(7), 1'b0);
      check("t5 valid after reset", 32'(ov0), 32'd1);
      idle(3);

      check("dut0 queue drained", 32'(q0.size()), 32'd0);
      check("dut1 queue drained", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
